io_bus_arbiter: RTL and testbench

Shares the single IO bus into `io_top` (`bus_cs`/`bus_wr`/`bus_rd`/`bus_addr`/`bus_wr_data`/`bus_rd_data`) between several bus masters: the RV32I core load/store unit and a future DMA engine. It uses registered round-robin arbitration with a per-master request/grant handshake, a one-cycle registered read-return path, and an optional bus lock for atomic multi-access sequences, such as a Matrix or CORDIC register burst. It sits between the masters and `io_top`; `io_top` itself is unchanged.

---
 rtl/io_bus_arbiter_pkg.sv | 21 ++
 rtl/io_bus_arbiter_if.sv | 36 +++
 rtl/io_bus_arbiter_rr_picker.sv | 33 +++
 rtl/io_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared state encoding, bus widths and request record for the IO bus arbiter.
package io_arb_pkg;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic              wr;
      logic              rd;
      logic              lock;
      logic [BUS_AW-1:0] addr;
      logic [BUS_DW-1:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Master-side request/grant signals plus the io_top bus, seen from both ends.
interface io_bus_arbiter_if #(
   parameter int NUM_MASTERS = 2
);
   import io_arb_pkg::*;

   logic [NUM_MASTERS-1:0]             m_req;
   logic [NUM_MASTERS-1:0]             m_wr;
   logic [NUM_MASTERS-1:0]             m_rd;
   logic [NUM_MASTERS-1:0]             m_lock;
   logic [NUM_MASTERS-1:0][BUS_AW-1:0] m_addr;
   logic [NUM_MASTERS-1:0][BUS_DW-1:0] m_wr_data;
   logic [NUM_MASTERS-1:0]             m_gnt;
   logic [NUM_MASTERS-1:0]             m_rd_valid;
   logic [BUS_DW-1:0]                  m_rd_data;

   logic                               bus_cs;
   logic                               bus_wr;
   logic                               bus_rd;
   logic [BUS_AW-1:0]                  bus_addr;
   logic [BUS_DW-1:0]                  bus_wr_data;
   logic [BUS_DW-1:0]                  bus_rd_data;

   modport slave (
      input  m_req, m_wr, m_rd, m_lock, m_addr, m_wr_data, bus_rd_data,
      output m_gnt, m_rd_valid, m_rd_data,
      output bus_cs, bus_wr, bus_rd, bus_addr, bus_wr_data
   );

   modport master (
      output m_req, m_wr, m_rd, m_lock, m_addr, m_wr_data, bus_rd_data,
      input  m_gnt, m_rd_valid, m_rd_data,
      input  bus_cs, bus_wr, bus_rd, bus_addr, bus_wr_data
   );

endinterface

// File: rtl/io_bus_arbiter_rr_picker.sv
// Round-robin winner selection: first set request at or after i_ptr, wrapping.
module rr_picker #(
   parameter int NUM_MASTERS = 2
) (
   input  logic [NUM_MASTERS-1:0]         i_req,
   input  logic [$clog2(NUM_MASTERS)-1:0] i_ptr,
   output logic [NUM_MASTERS-1:0]         o_onehot,
   output logic [$clog2(NUM_MASTERS)-1:0] o_idx,
   output logic                           o_any
);
   localparam int IW = $clog2(NUM_MASTERS);

   logic [IW:0] w_cand;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_cand   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_cand = {1'b0, i_ptr} + (IW+1)'(i);
         if (w_cand >= (IW+1)'(NUM_MASTERS)) begin
            w_cand = w_cand - (IW+1)'(NUM_MASTERS);
         end
         if (!o_any && i_req[w_cand[IW-1:0]]) begin
            o_any                     = 1'b1;
            o_idx                     = w_cand[IW-1:0];
            o_onehot[w_cand[IW-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin IO bus arbiter with registered issue, one-cycle read return and
// bounded bus lock for atomic register bursts.
module io_bus_arbiter
   import io_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int LOCK_MAX    = 16
) (
   input logic             clk,
   input logic             reset,
   io_bus_arbiter_if.slave bus
);
   localparam int IW  = $clog2(NUM_MASTERS);
   localparam int LCW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

   arb_state_t             r_state;
   arb_state_t             w_next;
   logic [IW-1:0]          r_rr_ptr;
   logic [IW-1:0]          r_owner;
   logic [NUM_MASTERS-1:0] r_gnt_oh;
   logic [LCW-1:0]         r_lock_cnt;
   logic                   r_wr;
   logic                   r_rd;
   logic                   r_lock;
   logic [BUS_AW-1:0]      r_addr;
   logic [BUS_DW-1:0]      r_wdata;
   logic [BUS_DW-1:0]      r_rd_data;
   logic [NUM_MASTERS-1:0] r_rd_valid;

   logic [NUM_MASTERS-1:0] w_pick_oh;
   logic [IW-1:0]          w_pick_idx;
   logic                   w_pick_any;
   logic [IW-1:0]          w_sel_idx;
   bus_req_t               w_sel;
   logic                   w_cont_ok;
   logic                   w_load;
   logic                   w_lock_inc;
   logic                   w_lock_clr;
   logic                   w_issue;

   rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .i_req    (bus.m_req),
      .i_ptr    (r_rr_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   // In IDLE the picker's winner is loaded; afterwards only the owner can reload.
   assign w_sel_idx   = (r_state == IDLE) ? w_pick_idx : r_owner;
   assign w_sel.wr    = bus.m_wr[w_sel_idx];
   assign w_sel.rd    = bus.m_rd[w_sel_idx] & ~bus.m_wr[w_sel_idx];
   assign w_sel.lock  = bus.m_lock[w_sel_idx];
   assign w_sel.addr  = bus.m_addr[w_sel_idx];
   assign w_sel.wdata = bus.m_wr_data[w_sel_idx];

   assign w_cont_ok = r_lock && (r_lock_cnt < LCW'(LOCK_MAX-1)) && bus.m_req[r_owner];

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_lock_inc = 1'b0;
      w_lock_clr = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_load = 1'b1;
               w_next = ISSUE;
            end
         end
         ISSUE, RD_WAIT: begin
            if (r_state == ISSUE && r_rd) begin
               w_next = RD_WAIT;
            end else if (w_cont_ok) begin
               w_load     = 1'b1;
               w_lock_inc = 1'b1;
               w_next     = ISSUE;
            end else begin
               w_lock_clr = 1'b1;
               w_next     = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_gnt_oh   <= '0;
         r_lock_cnt <= '0;
         r_wr       <= 1'b0;
         r_rd       <= 1'b0;
         r_lock     <= 1'b0;
         r_rd_valid <= '0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= (r_state == RD_WAIT) ? r_gnt_oh : '0;
         if (r_state == RD_WAIT) r_rd_data <= bus.bus_rd_data;
         if (r_state == ISSUE) begin
            r_rr_ptr <= (r_owner == IW'(NUM_MASTERS-1)) ? '0 : r_owner + 1'b1;
         end
         if (r_state == IDLE && w_pick_any) begin
            r_owner  <= w_pick_idx;
            r_gnt_oh <= w_pick_oh;
         end
         if (w_load) begin
            r_wr   <= w_sel.wr;
            r_rd   <= w_sel.rd;
            r_lock <= w_sel.lock;
         end
         if (w_lock_inc)      r_lock_cnt <= r_lock_cnt + 1'b1;
         else if (w_lock_clr) r_lock_cnt <= '0;
      end
   end

   // Address/data payload needs no reset: it only reaches the bus while issuing.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_addr  <= w_sel.addr;
         r_wdata <= w_sel.wdata;
      end
   end

   assign w_issue         = (r_state == ISSUE);
   assign bus.bus_cs      = w_issue;
   assign bus.bus_wr      = w_issue & r_wr;
   assign bus.bus_rd      = w_issue & r_rd;
   assign bus.bus_addr    = w_issue ? r_addr  : '0;
   assign bus.bus_wr_data = w_issue ? r_wdata : '0;
   assign bus.m_gnt       = w_issue ? r_gnt_oh : '0;
   assign bus.m_rd_valid  = r_rd_valid;
   assign bus.m_rd_data   = r_rd_data;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_io_bus_arbiter;
   import io_arb_pkg::*;

   localparam int NM = 2;
   localparam int LM = 4;
   localparam int IW = $clog2(NM);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   io_bus_arbiter_if #(.NUM_MASTERS(NM)) bus_if ();

   io_bus_arbiter #(.NUM_MASTERS(NM), .LOCK_MAX(LM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] io_resp(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEAD_BEEF : ~a;
   endfunction

   // io_top stand-in: read data appears the cycle after bus_rd
   always @(posedge clk) begin
      if (bus_if.bus_rd) bus_if.bus_rd_data <= io_resp(bus_if.bus_addr);
   end

   // Transaction-level reference: which transfer occupies the bus each cycle
   bit            model_on = 1'b0;
   bit            mb_idle, mb_issue, mb_rdret, mb_wr, mb_rd, mb_lock;
   logic [IW-1:0] mb_owner, mb_rr;
   int            mb_run;
   logic [31:0]   mb_addr, mb_wdata, mb_rdata;
   logic [NM-1:0] mb_rdv;

   task automatic mb_load(input logic [IW-1:0] o);
      mb_owner = o;
      mb_wr    = bus_if.m_wr[o];
      mb_rd    = bus_if.m_rd[o] & ~bus_if.m_wr[o];
      mb_lock  = bus_if.m_lock[o];
      mb_addr  = bus_if.m_addr[o];
      mb_wdata = bus_if.m_wr_data[o];
   endtask

   always @(posedge clk) begin : model
      bit            done, n_issue, n_rdret, n_idle, found;
      logic [IW-1:0] w, c;
      if (reset) begin
         model_on = 1'b1;
         mb_idle  = 1'b1;
         mb_issue = 1'b0;
         mb_rdret = 1'b0;
         mb_rr    = '0;
         mb_run   = 0;
         mb_owner = '0;
         mb_rdv   = '0;
         mb_rdata = '0;
      end else if (model_on) begin
         done = 0; n_issue = 0; n_rdret = 0; n_idle = 0;
         mb_rdv = '0;
         if (mb_rdret) begin
            mb_rdv   = NM'(1) << mb_owner;
            mb_rdata = io_resp(mb_addr);
            done     = 1;
         end
         if (mb_issue) begin
            mb_rr = IW'((int'(mb_owner) + 1) % NM);
            mb_run++;
            if (mb_rd) n_rdret = 1;
            else       done = 1;
         end
         if (done) begin
            if (mb_lock && mb_run < LM && bus_if.m_req[mb_owner]) begin
               n_issue = 1;
               mb_load(mb_owner);
            end else begin
               n_idle = 1;
               mb_run = 0;
            end
         end
         if (mb_idle) begin
            found = 0; w = '0;
            for (int k = 0; k < NM; k++) begin
               c = IW'((int'(mb_rr) + k) % NM);
               if (!found && bus_if.m_req[c]) begin
                  found = 1;
                  w     = c;
               end
            end
            if (found) begin
               n_issue = 1;
               mb_load(w);
            end else begin
               n_idle = 1;
            end
         end
         mb_idle  = n_idle;
         mb_issue = n_issue;
         mb_rdret = n_rdret;
      end
   end

   always @(negedge clk) begin : compare
      logic [NM-1:0] eg;
      if (model_on) begin
         eg = mb_issue ? (NM'(1) << mb_owner) : '0;
         check("m_gnt",       bus_if.m_gnt,       eg);
         check("m_rd_valid",  bus_if.m_rd_valid,  mb_rdv);
         check("m_rd_data",   bus_if.m_rd_data,   mb_rdata);
         check("bus_cs",      bus_if.bus_cs,      mb_issue);
         check("bus_wr",      bus_if.bus_wr,      mb_issue & mb_wr);
         check("bus_rd",      bus_if.bus_rd,      mb_issue & mb_rd);
         check("bus_addr",    bus_if.bus_addr,    mb_issue ? mb_addr  : 32'h0);
         check("bus_wr_data", bus_if.bus_wr_data, mb_issue ? mb_wdata : 32'h0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic clear_reqs();
      bus_if.m_req  = '0;
      bus_if.m_wr   = '0;
      bus_if.m_rd   = '0;
      bus_if.m_lock = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_reqs();
      @(negedge clk);
      reset = 1'b0;
      check("rst_gnt",     bus_if.m_gnt,      2'b00);
      check("rst_cs",      bus_if.bus_cs,     1'b0);
      check("rst_rd_data", bus_if.m_rd_data,  32'h0);
      check("rst_rd_vld",  bus_if.m_rd_valid, 2'b00);
   endtask

   int gr_own[$];
   int gr_cyc[$];
   int exp_own[5] = '{0, 0, 0, 0, 1};
   int exp_cyc[5] = '{1, 2, 3, 4, 6};
   int ngnt;
   bit got1;

   initial begin
      reset = 1'b1;
      clear_reqs();
      bus_if.m_addr    = '0;
      bus_if.m_wr_data = '0;

      // Single write
      do_reset();
      bus_if.m_req[0] = 1'b1; bus_if.m_wr[0] = 1'b1;
      bus_if.m_addr[0] = 32'h0000_0004; bus_if.m_wr_data[0] = 32'h0000_00A5;
      @(negedge clk);
      check("wr_gnt",  bus_if.m_gnt,       2'b01);
      check("wr_we",   bus_if.bus_wr,      1'b1);
      check("wr_addr", bus_if.bus_addr,    32'h4);
      check("wr_data", bus_if.bus_wr_data, 32'hA5);
      clear_reqs();
      @(negedge clk);
      check("wr_idle_cs",  bus_if.bus_cs, 1'b0);
      check("wr_idle_gnt", bus_if.m_gnt,  2'b00);

      // Fairness: two continuous writers
      do_reset();
      bus_if.m_addr[0] = 32'h1000; bus_if.m_addr[1] = 32'h2000;
      bus_if.m_wr_data[0] = 32'h1111; bus_if.m_wr_data[1] = 32'h2222;
      bus_if.m_req = 2'b11; bus_if.m_wr = 2'b11;
      gr_own.delete();
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (bus_if.m_gnt[0]) begin
            gr_own.push_back(0);
            bus_if.m_addr[0] = bus_if.m_addr[0] + 32'd4;
         end
         if (bus_if.m_gnt[1]) begin
            gr_own.push_back(1);
            bus_if.m_addr[1] = bus_if.m_addr[1] + 32'd4;
         end
      end
      clear_reqs();
      check("fair_count", gr_own.size(), 8);
      foreach (gr_own[k]) check("fair_order", gr_own[k], k % 2);

      // Read latency from M1
      do_reset();
      bus_if.m_req[1] = 1'b1; bus_if.m_rd[1] = 1'b1; bus_if.m_addr[1] = 32'h10;
      @(negedge clk);
      check("rd_gnt", bus_if.m_gnt,  2'b10);
      check("rd_re",  bus_if.bus_rd, 1'b1);
      clear_reqs();
      @(negedge clk);
      check("rd_vld_n2", bus_if.m_rd_valid, 2'b00);
      @(negedge clk);
      check("rd_vld_n3", bus_if.m_rd_valid, 2'b10);
      check("rd_data",   bus_if.m_rd_data,  32'hDEAD_BEEF);
      @(negedge clk);
      check("rd_vld_n4", bus_if.m_rd_valid, 2'b00);
      check("rd_hold",   bus_if.m_rd_data,  32'hDEAD_BEEF);

      // Lock cap: M0 locked write burst against M1
      do_reset();
      bus_if.m_addr[0] = 32'h100; bus_if.m_addr[1] = 32'h200;
      bus_if.m_req = 2'b11; bus_if.m_wr = 2'b11; bus_if.m_lock[0] = 1'b1;
      gr_own.delete(); gr_cyc.delete(); got1 = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (!got1) begin
            if (bus_if.m_gnt[0]) begin
               gr_own.push_back(0); gr_cyc.push_back(i);
               bus_if.m_addr[0] = bus_if.m_addr[0] + 32'd4;
            end
            if (bus_if.m_gnt[1]) begin
               gr_own.push_back(1); gr_cyc.push_back(i);
               got1 = 1'b1;
               clear_reqs();
            end
         end
      end
      clear_reqs();
      check("lock_count", gr_own.size(), 5);
      for (int k = 0; k < 5 && k < gr_own.size(); k++) begin
         check("lock_owner", gr_own[k], exp_own[k]);
         check("lock_cycle", gr_cyc[k], exp_cyc[k]);
      end

      // Locked reads from M1
      do_reset();
      bus_if.m_req[1] = 1'b1; bus_if.m_rd[1] = 1'b1; bus_if.m_lock[1] = 1'b1;
      bus_if.m_addr[1] = 32'h40;
      ngnt = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (bus_if.m_gnt[1]) begin
            ngnt++;
            bus_if.m_addr[1] = bus_if.m_addr[1] + 32'd4;
         end
      end
      clear_reqs();
      repeat (3) @(negedge clk);
      check("lock_rd_count", ngnt, 4);

      // Both strobes set is a write
      do_reset();
      bus_if.m_req[0] = 1'b1; bus_if.m_wr[0] = 1'b1; bus_if.m_rd[0] = 1'b1;
      bus_if.m_addr[0] = 32'h20; bus_if.m_wr_data[0] = 32'h77;
      @(negedge clk);
      check("both_gnt", bus_if.m_gnt,  2'b01);
      check("both_wr",  bus_if.bus_wr, 1'b1);
      check("both_rd",  bus_if.bus_rd, 1'b0);
      clear_reqs();
      @(negedge clk);
      check("both_vld2", bus_if.m_rd_valid, 2'b00);
      @(negedge clk);
      check("both_vld3", bus_if.m_rd_valid, 2'b00);

      // Reset while in RD_WAIT
      do_reset();
      bus_if.m_req[0] = 1'b1; bus_if.m_rd[0] = 1'b1; bus_if.m_addr[0] = 32'h30;
      @(negedge clk);
      check("rrst_re", bus_if.bus_rd, 1'b1);
      clear_reqs();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rrst_gnt", bus_if.m_gnt,      2'b00);
      check("rrst_vld", bus_if.m_rd_valid, 2'b00);
      check("rrst_cs",  bus_if.bus_cs,     1'b0);
      check("rrst_rdd", bus_if.m_rd_data,  32'h0);
      reset = 1'b0;
      bus_if.m_req = 2'b11; bus_if.m_wr = 2'b11;
      @(negedge clk);
      check("rrst_regnt", bus_if.m_gnt,      2'b01);
      check("rrst_vld2",  bus_if.m_rd_valid, 2'b00);
      clear_reqs();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
